// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register writer: FSM states, register map
// addresses and the default frame length.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    localparam int ADDR_EN_OUT_LO = 0;
    localparam int ADDR_EN_OUT_HI = 1;
    localparam int ADDR_EN_PWM_LO = 2;
    localparam int ADDR_EN_PWM_HI = 3;
    localparam int ADDR_DUTY      = 4;

    localparam int FRAME_BITS_DEF = 16;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronized value.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_chain;
    logic              r_prev;
    logic              w_sync;

    assign w_sync = r_chain[STAGES-1];

    // Chain resets low so a chip select held low through reset never looks
    // like a fresh falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
            r_prev  <= 1'b0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
            r_prev  <= w_sync;
        end
    end

    assign o_rise = w_sync & ~r_prev;
    assign o_fall = ~w_sync & r_prev;

endmodule

// File: rtl/spi_reg_writer.sv
// Write-only SPI mode-0 peripheral: receives R/W + address + data frames and
// commits them into the five PWM control registers.
module spi_reg_writer
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int MAX_ADDR    = ADDR_DUTY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe
);

    localparam int              CNT_W   = $clog2(FRAME_BITS + 2);
    localparam int              ADDR_W  = FRAME_BITS - 9;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_BITS + 1);

    logic                  w_sclk_rise;
    logic                  w_sclk_fall_unused;
    logic                  w_ncs_rise;
    logic                  w_ncs_fall;
    logic [SYNC_STAGES:0]  r_copi_chain;
    logic                  w_copi;

    state_t                r_state, w_state_next;
    logic [CNT_W-1:0]      r_cnt, w_cnt_next;
    logic [FRAME_BITS-1:0] r_shift, w_shift_next;
    logic                  w_commit;
    logic [ADDR_W-1:0]     w_addr;
    logic [7:0]            w_data;

    logic [7:0]            r_en_out_lo, r_en_out_hi, r_en_pwm_lo, r_en_pwm_hi, r_duty;
    logic                  r_wr_strobe;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .i_d    (sclk),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall_unused)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_ncs_sync (
        .clk    (clk),
        .rst    (rst),
        .i_d    (ncs),
        .o_rise (w_ncs_rise),
        .o_fall (w_ncs_fall)
    );

    // One extra stage keeps copi lined up with the delayed sclk copy used for edge detection.
    always_ff @(posedge clk) begin
        if (rst) r_copi_chain <= '0;
        else     r_copi_chain <= {r_copi_chain[SYNC_STAGES-1:0], copi};
    end
    assign w_copi = r_copi_chain[SYNC_STAGES];

    assign w_addr = r_shift[FRAME_BITS-2:8];
    assign w_data = r_shift[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_shift <= w_shift_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_shift_next = r_shift;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ncs_fall) begin
                    w_state_next = SHIFT;
                    w_cnt_next   = '0;
                    w_shift_next = '0;
                end
            end
            SHIFT: begin
                // Chip-select release wins over a coincident sclk edge.
                if (w_ncs_rise) begin
                    w_state_next = COMMIT;
                end else if (w_sclk_rise) begin
                    w_shift_next = {r_shift[FRAME_BITS-2:0], w_copi};
                    if (r_cnt != CNT_MAX) w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            COMMIT: begin
                w_state_next = IDLE;
                w_commit     = (r_cnt == CNT_W'(FRAME_BITS)) && r_shift[FRAME_BITS-1]
                               && (w_addr <= ADDR_W'(MAX_ADDR));
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_out_lo <= '0;
            r_en_out_hi <= '0;
            r_en_pwm_lo <= '0;
            r_en_pwm_hi <= '0;
            r_duty      <= '0;
            r_wr_strobe <= 1'b0;
        end else begin
            r_wr_strobe <= w_commit;
            if (w_commit) begin
                case (w_addr)
                    ADDR_W'(ADDR_EN_OUT_LO): r_en_out_lo <= w_data;
                    ADDR_W'(ADDR_EN_OUT_HI): r_en_out_hi <= w_data;
                    ADDR_W'(ADDR_EN_PWM_LO): r_en_pwm_lo <= w_data;
                    ADDR_W'(ADDR_EN_PWM_HI): r_en_pwm_hi <= w_data;
                    ADDR_W'(ADDR_DUTY):      r_duty      <= w_data;
                    default: ;
                endcase
            end
        end
    end

    assign en_reg_out_7_0  = r_en_out_lo;
    assign en_reg_out_15_8 = r_en_out_hi;
    assign en_reg_pwm_7_0  = r_en_pwm_lo;
    assign en_reg_pwm_15_8 = r_en_pwm_hi;
    assign pwm_duty_cycle  = r_duty;
    assign wr_strobe       = r_wr_strobe;

endmodule

// File: tb/tb_spi_reg_writer.sv
// Directed testbench for spi_reg_writer: drives SPI frames bit by bit and
// checks the register bank and write strobe against hand-computed values.
module tb_spi_reg_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       wr_strobe;

    int passed = 0;
    int total  = 0;
    int strobe_cnt = 0;

    spi_reg_writer #(.SYNC_STAGES(2), .FRAME_BITS(16), .MAX_ADDR(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_strobe       (wr_strobe)
    );

    always #5 clk = ~clk;

    // Counts strobe-high cycles, so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) strobe_cnt++;
    end

    task automatic spi_begin(input int half);
        @(negedge clk);
        ncs = 1'b0;
        repeat (half) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [31:0] val, input int n, input int half);
        for (int i = n - 1; i >= 0; i--) begin
            copi = val[i];
            repeat (half) @(negedge clk);
            sclk = 1'b1;
            repeat (half) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_end(input int half);
        repeat (half) @(negedge clk);
        ncs = 1'b1;
    endtask

    task automatic send_frame(input logic [31:0] val, input int n, input int half);
        spi_begin(half);
        spi_bits(val, n, half);
        spi_end(half);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (en_reg_out_7_0 !== 8'h00) $display("FAIL reset_out_lo got %h want 00", en_reg_out_7_0); else passed++;
        total++; if (en_reg_out_15_8 !== 8'h00) $display("FAIL reset_out_hi got %h want 00", en_reg_out_15_8); else passed++;
        total++; if (en_reg_pwm_7_0 !== 8'h00) $display("FAIL reset_pwm_lo got %h want 00", en_reg_pwm_7_0); else passed++;
        total++; if (en_reg_pwm_15_8 !== 8'h00) $display("FAIL reset_pwm_hi got %h want 00", en_reg_pwm_15_8); else passed++;
        total++; if (pwm_duty_cycle !== 8'h00) $display("FAIL reset_duty got %h want 00", pwm_duty_cycle); else passed++;
        total++; if (strobe_cnt !== 0) $display("FAIL reset_strobe got %0d want 0", strobe_cnt); else passed++;
    endtask

    task automatic test_single_write;
        int start;
        start = strobe_cnt;
        send_frame(32'h8455, 16, 4);
        repeat (3) @(negedge clk);
        total++; if (pwm_duty_cycle !== 8'h00) $display("FAIL single_early got %h want 00", pwm_duty_cycle); else passed++;
        repeat (2) @(negedge clk);
        total++; if (pwm_duty_cycle !== 8'h55) $display("FAIL single_duty got %h want 55", pwm_duty_cycle); else passed++;
        total++; if (strobe_cnt - start !== 1) $display("FAIL single_strobe got %0d want 1", strobe_cnt - start); else passed++;
        total++; if ({en_reg_out_7_0, en_reg_out_15_8} !== 16'h0000)
            $display("FAIL single_others_out got %h want 0000", {en_reg_out_7_0, en_reg_out_15_8}); else passed++;
        total++; if ({en_reg_pwm_7_0, en_reg_pwm_15_8} !== 16'h0000)
            $display("FAIL single_others_pwm got %h want 0000", {en_reg_pwm_7_0, en_reg_pwm_15_8}); else passed++;
        repeat (4) @(negedge clk);
        total++; if (strobe_cnt - start !== 1) $display("FAIL single_strobe_late got %0d want 1", strobe_cnt - start); else passed++;
    endtask

    task automatic test_multi_write;
        int start;
        logic [15:0] frames [4];
        frames[0] = 16'h80F0; frames[1] = 16'h810F; frames[2] = 16'h82AA; frames[3] = 16'h83CC;
        start = strobe_cnt;
        for (int i = 0; i < 4; i++) begin
            send_frame({16'h0, frames[i]}, 16, 4);
            repeat (6) @(negedge clk);
        end
        total++; if (en_reg_out_7_0 !== 8'hF0) $display("FAIL multi_out_lo got %h want F0", en_reg_out_7_0); else passed++;
        total++; if (en_reg_out_15_8 !== 8'h0F) $display("FAIL multi_out_hi got %h want 0F", en_reg_out_15_8); else passed++;
        total++; if (en_reg_pwm_7_0 !== 8'hAA) $display("FAIL multi_pwm_lo got %h want AA", en_reg_pwm_7_0); else passed++;
        total++; if (en_reg_pwm_15_8 !== 8'hCC) $display("FAIL multi_pwm_hi got %h want CC", en_reg_pwm_15_8); else passed++;
        total++; if (pwm_duty_cycle !== 8'h55) $display("FAIL multi_duty_hold got %h want 55", pwm_duty_cycle); else passed++;
        total++; if (strobe_cnt - start !== 4) $display("FAIL multi_strobe got %0d want 4", strobe_cnt - start); else passed++;
    endtask

    task automatic test_discard;
        logic [31:0] vals [4];
        int          lens [4];
        int          start;
        vals[0] = 32'h0412;  lens[0] = 16;   // read frame
        vals[1] = 32'h8512;  lens[1] = 16;   // address beyond the register map
        vals[2] = 32'h4433;  lens[2] = 15;   // short
        vals[3] = 32'h18433; lens[3] = 17;   // long; last 16 bits look like a valid write
        for (int i = 0; i < 4; i++) begin
            start = strobe_cnt;
            send_frame(vals[i], lens[i], 4);
            repeat (6) @(negedge clk);
            total++;
            if ({en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle} !== 40'hF00FAACC55)
                $display("FAIL discard%0d_regs got %h want F00FAACC55", i,
                         {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle});
            else passed++;
            total++; if (strobe_cnt - start !== 0) $display("FAIL discard%0d_strobe got %0d want 0", i, strobe_cnt - start); else passed++;
        end
    endtask

    task automatic test_reset_midframe;
        int start;
        start = strobe_cnt;
        spi_begin(4);
        spi_bits(32'h82, 8, 4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        spi_bits(32'h99, 8, 4);
        spi_end(4);
        repeat (6) @(negedge clk);
        total++; if (en_reg_pwm_7_0 !== 8'h00) $display("FAIL midreset_pwm_lo got %h want 00", en_reg_pwm_7_0); else passed++;
        total++; if (strobe_cnt - start !== 0) $display("FAIL midreset_strobe got %0d want 0", strobe_cnt - start); else passed++;
        start = strobe_cnt;
        send_frame(32'h8299, 16, 4);
        repeat (6) @(negedge clk);
        total++; if (en_reg_pwm_7_0 !== 8'h99) $display("FAIL midreset_rewrite got %h want 99", en_reg_pwm_7_0); else passed++;
        total++; if (strobe_cnt - start !== 1) $display("FAIL midreset_rewrite_strobe got %0d want 1", strobe_cnt - start); else passed++;
    endtask

    task automatic test_timing;
        send_frame(32'h84FF, 16, 3);
        repeat (6) @(negedge clk);
        total++; if (pwm_duty_cycle !== 8'hFF) $display("FAIL timing_min got %h want FF", pwm_duty_cycle); else passed++;
        send_frame(32'h8400, 16, 3);
        repeat (6) @(negedge clk);
        total++; if (pwm_duty_cycle !== 8'h00) $display("FAIL timing_clear got %h want 00", pwm_duty_cycle); else passed++;
        send_frame(32'h84FF, 16, 20);
        repeat (6) @(negedge clk);
        total++; if (pwm_duty_cycle !== 8'hFF) $display("FAIL timing_slow got %h want FF", pwm_duty_cycle); else passed++;
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_multi_write;
        test_discard;
        test_reset_midframe;
        test_timing;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
